// File: rtl/ext_sram_ctrl.sv
`timescale 1ns/1ps
// ext_sram_ctrl
// Bridges a single-word memory-interface port onto an asynchronous 16-bit
// external SRAM. Each accepted request runs one fixed-length SRAM cycle of
// WAIT_CYCLES+1 clocks. The block then parks in DONE until the master drops
// its request.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst          asynchronous active-high reset
//   addr_i       word address from the master
//   re_i, we_i   read / write request, held until needWait_o is seen low
//   data_io      master data bus: master drives on writes, block on reads
//   needWait_o   high while the requested access is not complete
//   sram_addr_o  SRAM address pins (hold their last value between accesses)
//   sram_dq_io   SRAM data pins
//   sram_ce_n    SRAM chip enable, active low
//   sram_oe_n    SRAM output enable, active low
//   sram_we_n    SRAM write enable, active low
module ext_sram_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              re_i,
  input  logic              we_i,
  inout  wire  [15:0]       data_io,
  output logic              needWait_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  inout  wire  [15:0]       sram_dq_io,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_wdata;
  logic [15:0]         r_rdata;
  logic                r_is_wr;

  logic                w_req;
  logic                w_start;
  logic                w_capture;
  logic                w_need_wait;
  logic                w_ce_n;
  logic                w_oe_n;
  logic                w_we_n;
  logic                w_dq_oe;
  logic                w_dio_oe;

  assign w_req = re_i | we_i;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_start      = 1'b0;
    w_capture    = 1'b0;
    w_need_wait  = 1'b0;
    w_ce_n       = 1'b1;
    w_oe_n       = 1'b1;
    w_we_n       = 1'b1;
    w_dq_oe      = 1'b0;
    w_dio_oe     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_need_wait  = 1'b1;
          w_start      = 1'b1;
          w_cnt_next   = 4'(WAIT_CYCLES);
          w_state_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_need_wait = 1'b1;
        w_ce_n      = 1'b0;
        if (r_is_wr) begin
          w_dq_oe = 1'b1;
          // Release we_n one cycle early so the SRAM sees data held past
          // the rising edge of the write strobe.
          w_we_n  = (r_cnt == 4'd0);
        end else begin
          w_oe_n = 1'b0;
        end
        if (r_cnt == 4'd0) begin
          w_capture    = ~r_is_wr;
          w_state_next = S_DONE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_DONE: begin
        // Only a completed read is returned, and only while still requested.
        w_dio_oe = ~r_is_wr & re_i;
        if (!w_req) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= 16'h0000;
      r_rdata <= 16'h0000;
      r_is_wr <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_start) begin
        r_addr  <= addr_i;
        // Write wins when both requests arrive together.
        r_is_wr <= we_i;
        if (we_i) begin
          r_wdata <= data_io;
        end
      end
      if (w_capture) begin
        r_rdata <= sram_dq_io;
      end
    end
  end

  // The state register resets asynchronously, so the strobes decoded from
  // it go inactive as soon as rst rises. needWait_o is gated separately
  // because in IDLE it follows the request inputs directly.
  assign needWait_o  = w_need_wait & ~rst;
  assign sram_ce_n   = w_ce_n;
  assign sram_oe_n   = w_oe_n;
  assign sram_we_n   = w_we_n;
  assign sram_addr_o = r_addr;
  assign sram_dq_io  = w_dq_oe  ? r_wdata : 16'bz;
  assign data_io     = w_dio_oe ? r_rdata : 16'bz;

endmodule

// File: tb/tb_ext_sram_ctrl.sv
`timescale 1ns/1ps
module tb_ext_sram_ctrl;
  localparam int AW = 18;
  localparam int W  = 2;
  localparam logic [AW-1:0] POOL [8] = '{18'h00123, 18'h00456, 18'h00789, 18'h00000,
                                         18'h3FFFE, 18'h12345, 18'h0ABCD, 18'h20000};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr_i = '0;
  logic          re_i = 1'b0;
  logic          we_i = 1'b0;
  logic          tb_drv = 1'b0;
  logic [15:0]   tb_data = 16'h0000;
  wire  [15:0]   data_io;
  wire  [15:0]   sram_dq_io;
  logic          needWait_o;
  logic [AW-1:0] sram_addr_o;
  logic          sram_ce_n, sram_oe_n, sram_we_n;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en   = 1'b0;
  logic init_mem = 1'b1;
  logic [15:0] init_val [8];

  logic [15:0] sram_mem [0:(1<<AW)-1];
  logic [15:0] ref_mem  [0:(1<<AW)-1];

  ext_sram_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .re_i(re_i), .we_i(we_i),
    .data_io(data_io), .needWait_o(needWait_o), .sram_addr_o(sram_addr_o),
    .sram_dq_io(sram_dq_io), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // Undriven buses read as all ones, so "Z" is observed as 16'hFFFF.
  for (genvar gi = 0; gi < 16; gi++) begin : g_pull
    pullup pu_d (data_io[gi]);
    pullup pu_q (sram_dq_io[gi]);
  end

  assign data_io = tb_drv ? tb_data : 16'bz;

  // SRAM device: output while selected with oe_n low, write on clock edges
  // where we_n is low.
  assign sram_dq_io = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_addr_o] : 16'bz;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 8; i++) sram_mem[POOL[i]] <= init_val[i];
    end else if (!sram_ce_n && !sram_we_n) begin
      sram_mem[sram_addr_o] <= sram_dq_io;
    end
  end

  // Reference model: a request accepted at the end of an idle cycle occupies
  // the SRAM for the next W+1 cycles (k = cycles elapsed, 0..W); the memory
  // effect takes place when the last of those cycles ends; the controller
  // then waits for the master to drop its request.
  logic        m_busy = 1'b0, m_done = 1'b0, m_wr = 1'b0;
  int          m_k = 0;
  logic [AW-1:0] m_addr = '0;
  logic [15:0] m_wdata = 16'h0000, m_rdata = 16'h0000;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_k <= 0; m_addr <= '0; m_rdata <= 16'h0000;
      if (init_mem) begin
        for (int i = 0; i < 8; i++) ref_mem[POOL[i]] <= init_val[i];
      end
    end else if (m_busy) begin
      if (m_k == W) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        if (m_wr) ref_mem[m_addr] <= m_wdata;
        else      m_rdata <= ref_mem[m_addr];
      end else begin
        m_k <= m_k + 1;
      end
    end else if (m_done) begin
      if (!re_i && !we_i) m_done <= 1'b0;
    end else if (re_i || we_i) begin
      m_busy <= 1'b1;
      m_k    <= 0;
      m_wr   <= we_i;
      m_addr <= addr_i;
      if (we_i) m_wdata <= tb_drv ? tb_data : 16'hFFFF;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic        e_wait, e_ce, e_oe, e_we;
  logic [15:0] e_dq, e_dio;

  always @(negedge clk) begin
    if (chk_en) begin
      e_wait = rst ? 1'b0 : (m_busy ? 1'b1 : (m_done ? 1'b0 : (re_i | we_i)));
      e_ce   = !m_busy;
      e_oe   = !(m_busy && !m_wr);
      e_we   = !(m_busy && m_wr && (m_k < W));
      e_dq   = m_busy ? (m_wr ? m_wdata : ref_mem[m_addr]) : 16'hFFFF;
      e_dio  = (m_done && !m_wr && re_i) ? m_rdata : (tb_drv ? tb_data : 16'hFFFF);
      check("cyc_needWait", 32'(needWait_o), 32'(e_wait));
      check("cyc_ce_n", 32'(sram_ce_n), 32'(e_ce));
      check("cyc_oe_n", 32'(sram_oe_n), 32'(e_oe));
      check("cyc_we_n", 32'(sram_we_n), 32'(e_we));
      check("cyc_addr", 32'(sram_addr_o), 32'(m_addr));
      check("cyc_dq", 32'(sram_dq_io), 32'(e_dq));
      check("cyc_data_io", 32'(data_io), 32'(e_dio));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int oe_fall, oe_low, we_low, dio_drv, bound;
    logic prev_oe;
    for (int i = 0; i < 8; i++) init_val[i] = 16'($urandom_range(0, 16'hFFFE));
    // Reset: requests must not raise needWait_o while rst is high.
    @(posedge clk); #1;
    chk_en = 1'b1;
    re_i = 1'b1; #1;
    check("rst_needWait", 32'(needWait_o), 32'd0);
    check("rst_ce_n", 32'(sram_ce_n), 32'd1);
    check("rst_addr", 32'(sram_addr_o), 32'd0);
    check("rst_data_io", 32'(data_io), 32'hFFFF);
    re_i = 1'b0;
    repeat (2) next_cycle();
    init_mem = 1'b0;
    rst = 1'b0;

    // Write 0xBEEF to 0x00123; cycle 0 is the request cycle.
    next_cycle();
    we_i = 1'b1; addr_i = 18'h00123; tb_data = 16'hBEEF; tb_drv = 1'b1;
    @(negedge clk);
    check("wr_c0_needWait", 32'(needWait_o), 32'd1);
    check("wr_c0_we_n", 32'(sram_we_n), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      tb_drv = 1'b0;
      @(negedge clk);
      check("wr_needWait", 32'(needWait_o), (c <= 3) ? 32'd1 : 32'd0);
      check("wr_we_n", 32'(sram_we_n), (c == 1 || c == 2) ? 32'd0 : 32'd1);
      check("wr_dq", 32'(sram_dq_io), (c <= 3) ? 32'hBEEF : 32'hFFFF);
    end
    check("wr_mem", 32'(sram_mem[18'h00123]), 32'hBEEF);
    next_cycle(); we_i = 1'b0;

    // Read it back, holding re_i for 5 DONE cycles.
    next_cycle();
    re_i = 1'b1; addr_i = 18'h00123;
    @(negedge clk);
    check("rd_c0_needWait", 32'(needWait_o), 32'd1);
    prev_oe = sram_oe_n; oe_fall = 0; oe_low = 0;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      if (c == 9) re_i = 1'b0;
      @(negedge clk);
      if (prev_oe && !sram_oe_n) oe_fall++;
      if (!sram_oe_n) oe_low++;
      prev_oe = sram_oe_n;
      if (c >= 4 && c <= 8) begin
        check("rd_done_needWait", 32'(needWait_o), 32'd0);
        check("rd_done_data", 32'(data_io), 32'hBEEF);
      end
      if (c == 9) check("rd_drop_data_z", 32'(data_io), 32'hFFFF);
    end
    check("rd_oe_pulses", 32'(oe_fall), 32'd1);
    check("rd_oe_low_cycles", 32'(oe_low), 32'd3);

    // re_i and we_i together: write wins, data_io never driven by the block.
    next_cycle();
    re_i = 1'b1; we_i = 1'b1; addr_i = 18'h00456; tb_data = 16'h1234; tb_drv = 1'b1;
    @(negedge clk);
    we_low = 0; oe_low = 0; dio_drv = 0; bound = 0;
    do begin
      next_cycle();
      tb_drv = 1'b0;
      @(negedge clk);
      if (!sram_we_n) we_low++;
      if (!sram_oe_n) oe_low++;
      if (data_io !== 16'hFFFF) dio_drv++;
      bound++;
    end while (needWait_o && bound < 20);
    check("both_bound", 32'(bound), 32'd4);
    next_cycle(); re_i = 1'b0; we_i = 1'b0;
    @(negedge clk);
    if (data_io !== 16'hFFFF) dio_drv++;
    check("both_mem", 32'(sram_mem[18'h00456]), 32'h1234);
    check("both_we_low", 32'(we_low), 32'd2);
    check("both_oe_low", 32'(oe_low), 32'd0);
    check("both_data_io_driven", 32'(dio_drv), 32'd0);

    // Write request dropped after the first ACCESS cycle.
    next_cycle();
    we_i = 1'b1; addr_i = 18'h00789; tb_data = 16'hCAFE; tb_drv = 1'b1;
    next_cycle(); tb_drv = 1'b0;
    @(negedge clk); check("drop_c1_we_n", 32'(sram_we_n), 32'd0);
    next_cycle(); we_i = 1'b0;
    @(negedge clk); check("drop_c2_we_n", 32'(sram_we_n), 32'd0);
    next_cycle();
    @(negedge clk); check("drop_c3_we_n", 32'(sram_we_n), 32'd1);
    check("drop_c3_needWait", 32'(needWait_o), 32'd1);
    next_cycle();
    @(negedge clk); check("drop_c4_needWait", 32'(needWait_o), 32'd0);
    next_cycle();
    re_i = 1'b1;
    @(negedge clk); check("drop_c5_idle_accepts", 32'(needWait_o), 32'd1);
    next_cycle();
    @(negedge clk); check("drop_c6_oe_n", 32'(sram_oe_n), 32'd0);
    repeat (3) next_cycle();
    @(negedge clk); check("drop_readback", 32'(data_io), 32'hCAFE);
    next_cycle(); re_i = 1'b0;
    next_cycle();

    // Reset in the middle of a write.
    next_cycle();
    we_i = 1'b1; addr_i = 18'h3FFFF; tb_data = 16'hA5A5; tb_drv = 1'b1;
    next_cycle(); tb_drv = 1'b0;
    @(negedge clk); check("rstw_c1_we_n", 32'(sram_we_n), 32'd0);
    next_cycle();
    rst = 1'b1; #1;
    check("rstw_we_n", 32'(sram_we_n), 32'd1);
    check("rstw_dq_z", 32'(sram_dq_io), 32'hFFFF);
    check("rstw_needWait", 32'(needWait_o), 32'd0);
    check("rstw_ce_n", 32'(sram_ce_n), 32'd1);
    next_cycle();
    rst = 1'b0; we_i = 1'b0;
    @(negedge clk);
    check("rstw_post_needWait", 32'(needWait_o), 32'd0);
    check("rstw_post_addr", 32'(sram_addr_o), 32'd0);
    next_cycle();
    re_i = 1'b1; addr_i = 18'h00123;
    @(negedge clk); check("rstw_idle_accepts", 32'(needWait_o), 32'd1);
    repeat (4) next_cycle();
    @(negedge clk); check("rstw_readback", 32'(data_io), 32'hBEEF);
    next_cycle(); re_i = 1'b0;

    // Randomized traffic over a small address pool, including early drops.
    for (int t = 0; t < 80; t++) begin
      int kind, hold;
      bound = 0;
      while ((m_busy || m_done) && bound < 30) begin
        next_cycle();
        bound++;
      end
      if (bound >= 30) check("rand_idle_bound", 32'(bound), 32'd0);
      repeat ($urandom_range(0, 2)) next_cycle();
      kind = $urandom_range(0, 2);
      hold = $urandom_range(1, W + 7);
      next_cycle();
      re_i = (kind != 1); we_i = (kind != 0);
      addr_i = POOL[$urandom_range(0, 7)];
      tb_data = 16'($urandom_range(0, 16'hFFFE));
      tb_drv = we_i;
      for (int h = 1; h < hold; h++) begin
        next_cycle();
        tb_drv = 1'b0;
        addr_i = AW'($urandom);
      end
      next_cycle();
      tb_drv = 1'b0; re_i = 1'b0; we_i = 1'b0;
    end
    repeat (W + 4) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
